// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between a buffered CPU write stream and an LCD read stream.
// Reads bypass the memory when a buffered write to the same address is still pending.
module mem_arbiter #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned MAX_RD_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr_en,
    input  logic [31:0] cpu_wr_addr,
    input  logic [31:0] cpu_wr_data,
    output logic        cpu_stall,
    input  logic        lcd_rd_req,
    input  logic [5:0]  lcd_rd_addr,
    output logic        lcd_rd_gnt,
    output logic        lcd_rd_valid,
    output logic [8:0]  lcd_rd_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [5:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [8:0]  mem_rdata
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STK_W = $clog2(MAX_RD_STREAK + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(MAX_RD_STREAK);

    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_WR   = 2'd1;
    localparam logic [1:0] GNT_RD   = 2'd2;

    logic [5:0]       buf_addr [FIFO_DEPTH];
    logic [31:0]      buf_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [STK_W-1:0] rd_streak_q;
    logic             rd_valid_q, rd_hit_q;
    logic [8:0]       rd_hit_data_q, rd_data_q;

    logic       full, empty, push, pop;
    logic [1:0] gnt_sel;
    logic       hit;
    logic [8:0] hit_data;
    logic [8:0] rd_data_now;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^cpu_wr_addr[31:6];

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        gnt_sel = GNT_IDLE;
        if (rst) begin
            gnt_sel = GNT_IDLE;
        end else if (full) begin
            gnt_sel = GNT_WR;
        end else if (lcd_rd_req && (rd_streak_q < STREAK_MAX)) begin
            gnt_sel = GNT_RD;
        end else if (!empty) begin
            gnt_sel = GNT_WR;
        end else if (lcd_rd_req) begin
            gnt_sel = GNT_RD;
        end
    end

    assign push = !rst && cpu_wr_en && !full;
    assign pop  = (gnt_sel == GNT_WR);

    // Walk oldest to newest so the newest matching entry wins; same-cycle pushes are not visible.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (buf_addr[idx] == lcd_rd_addr)) begin
                hit      = 1'b1;
                hit_data = buf_data[idx][8:0];
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (gnt_sel)
            GNT_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = buf_addr[rd_ptr_q];
                mem_wdata = buf_data[rd_ptr_q];
            end
            GNT_RD: begin
                if (!hit) begin
                    mem_en   = 1'b1;
                    mem_addr = lcd_rd_addr;
                end
            end
            default: ;
        endcase
    end

    assign cpu_stall  = !rst && full;
    assign lcd_rd_gnt = (gnt_sel == GNT_RD);

    // Bypass data was captured at grant; memory data arrives on the valid cycle itself.
    assign rd_data_now  = rd_hit_q ? rd_hit_data_q : mem_rdata;
    assign lcd_rd_valid = !rst && rd_valid_q;
    assign lcd_rd_data  = rst ? 9'd0 : (rd_valid_q ? rd_data_now : rd_data_q);

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr_q] <= cpu_wr_addr[5:0];
            buf_data[wr_ptr_q] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_streak_q   <= '0;
            rd_valid_q    <= 1'b0;
            rd_hit_q      <= 1'b0;
            rd_hit_data_q <= '0;
            rd_data_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            if (pop || empty) begin
                rd_streak_q <= '0;
            end else if (lcd_rd_gnt && (rd_streak_q != STREAK_MAX)) begin
                rd_streak_q <= rd_streak_q + 1'b1;
            end

            rd_valid_q <= lcd_rd_gnt;
            if (lcd_rd_gnt) begin
                rd_hit_q      <= hit;
                rd_hit_data_q <= hit_data;
            end
            if (rd_valid_q) begin
                rd_data_q <= rd_data_now;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a queue-based reference model
// plus a simple synchronous memory.
module tb_mem_arbiter;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STREAK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr_en;
    logic [31:0] cpu_wr_addr, cpu_wr_data;
    logic        cpu_stall;
    logic        lcd_rd_req;
    logic [5:0]  lcd_rd_addr;
    logic        lcd_rd_gnt, lcd_rd_valid;
    logic [8:0]  lcd_rd_data;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  mem_rdata;

    mem_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_RD_STREAK(STREAK)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_stall   (cpu_stall),
        .lcd_rd_req  (lcd_rd_req),
        .lcd_rd_addr (lcd_rd_addr),
        .lcd_rd_gnt  (lcd_rd_gnt),
        .lcd_rd_valid(lcd_rd_valid),
        .lcd_rd_data (lcd_rd_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } ent_t;

    // Reference model state
    ent_t       q[$];
    int         streak;
    logic       exp_valid;
    logic [8:0] exp_rdata;
    logic [8:0] exp_mem [64];

    // Memory seen by the DUT
    logic [8:0] mem [64];

    int   n_checks = 0;
    int   n_errors = 0;
    logic last_gnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [31:0] wa,
                        input logic [31:0] wd, input logic rq, input logic [5:0] ra);
        logic       full, rd, wr, hit;
        logic [8:0] hdata;
        logic       e_en;
        logic [5:0] e_addr;
        logic [31:0] e_wdata;
        logic       s_en, s_we;
        logic [5:0] s_addr;
        logic [31:0] s_wdata;
        @(negedge clk);
        rst = r; cpu_wr_en = we; cpu_wr_addr = wa; cpu_wr_data = wd;
        lcd_rd_req = rq; lcd_rd_addr = ra;
        #1;
        if (r) begin
            check("rst_stall", cpu_stall, 0);
            check("rst_gnt", lcd_rd_gnt, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_valid", lcd_rd_valid, 0);
            check("rst_rdata", lcd_rd_data, 0);
            q.delete();
            streak    = 0;
            exp_valid = 1'b0;
            exp_rdata = '0;
            last_gnt  = 1'b0;
        end else begin
            full = (q.size() == DEPTH);
            wr = 1'b0; rd = 1'b0;
            if (full) wr = 1'b1;
            else if (rq && streak < STREAK) rd = 1'b1;
            else if (q.size() > 0) wr = 1'b1;
            else if (rq) rd = 1'b1;
            hit = 1'b0; hdata = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].a == ra) begin
                    hit = 1'b1; hdata = q[i].d[8:0]; break;
                end
            end
            e_en    = wr || (rd && !hit);
            e_addr  = wr ? q[0].a : ((rd && !hit) ? ra : 6'd0);
            e_wdata = wr ? q[0].d : 32'd0;
            check("stall", cpu_stall, full);
            check("gnt", lcd_rd_gnt, rd);
            check("mem_en", mem_en, e_en);
            check("mem_we", mem_we, wr);
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("valid", lcd_rd_valid, exp_valid);
            check("rdata", lcd_rd_data, exp_rdata);
            exp_valid = rd;
            if (rd) exp_rdata = hit ? hdata : exp_mem[ra];
            if (wr || q.size() == 0) streak = 0;
            else if (rd && streak < STREAK) streak++;
            if (wr) begin
                exp_mem[q[0].a] = q[0].d[8:0];
                void'(q.pop_front());
            end
            if (we && !full) q.push_back('{a: wa[5:0], d: wd});
            last_gnt = rd;
        end
        s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
        @(posedge clk);
        #1;
        if (s_en && s_we) mem[s_addr] = s_wdata[8:0];
        else if (s_en) mem_rdata = mem[s_addr];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        rq_pend;
        logic [5:0]  rq_addr;
        int          wr_pct;
        logic [31:0] wa;

        rst = 1'b1; cpu_wr_en = 0; cpu_wr_addr = 0; cpu_wr_data = 0;
        lcd_rd_req = 0; lcd_rd_addr = 0; mem_rdata = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 9'(i * 37 + 5);
            exp_mem[i] = 9'(i * 37 + 5);
        end
        mem[16] = 9'h0AB; exp_mem[16] = 9'h0AB;
        streak = 0; exp_valid = 0; exp_rdata = 0; last_gnt = 0;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

        // In-order drain of three writes
        step(0, 1, 32'd1, 32'hA, 0, 0);
        step(0, 1, 32'd2, 32'hB, 0, 0);
        step(0, 1, 32'd3, 32'hC, 0, 0);
        idle(3);

        // Fill under read pressure; fifth strobe lands on a full buffer
        for (int i = 0; i < 5; i++) step(0, 1, 32'(8 + i), 32'(100 + i), 1, 6'h30);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 6'h30);
        idle(6);

        // Read streak limit with one buffered entry
        step(0, 1, 32'd20, 32'h55, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 6'h21);
        idle(2);

        // Bypass from buffer, then a plain memory read
        step(0, 1, 32'h05, 32'h1FF, 0, 0);
        step(0, 0, 0, 0, 1, 6'h05);
        idle(3);
        step(0, 0, 0, 0, 1, 6'h10);
        idle(2);

        // Reset with three entries buffered and a read in flight
        step(0, 1, 32'd40, 32'h11, 0, 0);
        step(0, 1, 32'd41, 32'h22, 0, 0);
        step(0, 1, 32'd42, 32'h33, 1, 6'h29);
        step(1, 1, 32'd43, 32'h44, 1, 6'h29);
        idle(4);

        // Randomized traffic over a small address window to exercise bypass hits
        rq_pend = 0; rq_addr = 0; wr_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) wr_pct = $urandom_range(10, 95);
            if (!rq_pend && ($urandom_range(0, 99) < 45)) begin
                rq_pend = 1;
                rq_addr = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            end
            wa = {$urandom, 6'd0} | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                step(1, 1, wa, $urandom, rq_pend, rq_addr);
                rq_pend = 0;
            end else begin
                step(0, $urandom_range(0, 99) < wr_pct, wa, $urandom, rq_pend, rq_addr);
                if (last_gnt) rq_pend = 0;
            end
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: write-buffer entries, power of two, range 2..16.
REQ-002 Parameter MAX_RD_STREAK, default 4: maximum consecutive read grants while the buffer is non-empty.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_wr_en  input  1  CPU write strobe, one write per cycle.
REQ-006 cpu_wr_addr  input  32  CPU write address; only bits [5:0] are used, bits [31:6] are ignored.
REQ-007 cpu_wr_data  input  32  CPU write data.
REQ-008 cpu_stall  output  1  write buffer full; a strobe in this cycle is not accepted.
REQ-009 lcd_rd_req  input  1  LCD read request, level, held until granted.
REQ-010 lcd_rd_addr  input  6  LCD read address, held stable while lcd_rd_req is high.
REQ-011 lcd_rd_gnt  output  1  read accepted this cycle (combinational).
REQ-012 lcd_rd_valid  output  1  one-cycle pulse, cycle after grant.
REQ-013 lcd_rd_data  output  9  read data, held until the next lcd_rd_valid.
REQ-014 mem_en  output  1  memory port access this cycle.
REQ-015 mem_we  output  1  1 = write, 0 = read; meaningful only when mem_en is high.
REQ-016 mem_addr  output  6  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  9  synchronous read data, valid the cycle after a read access.

Function
REQ-019 Write buffer
- In-order FIFO of {addr[5:0], data[31:0]}, FIFO_DEPTH entries.
- cpu_stall = (count == FIFO_DEPTH).
- Push when cpu_wr_en && !cpu_stall; a strobe while stalled is dropped, even if a pop occurs in the same cycle.
REQ-020 Push and pop in the same cycle leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 Arbitration, combinational each cycle, in priority order:
- (a) FIFO full -> write grant;
- (b) lcd_rd_req && rd_streak < MAX_RD_STREAK -> read grant;
- (c) FIFO non-empty -> write grant;
- (d) lcd_rd_req -> read grant (FIFO empty);
- (e) otherwise idle.
REQ-022 Write grant: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head; head popped at the edge.
REQ-023 Read grant:
- lcd_rd_gnt=1.
- If lcd_rd_addr matches any buffered entry, no memory access (mem_en=0); the read is served from the newest matching entry's data[8:0].
- Otherwise mem_en=1, mem_we=0, mem_addr=lcd_rd_addr.
REQ-024 Match check includes an entry popped in the same cycle; it excludes an entry pushed in the same cycle.
REQ-025 Read latency is fixed at 1 cycle for both paths: lcd_rd_valid=1 and lcd_rd_data updated on the cycle after lcd_rd_gnt.
REQ-026 rd_streak counter (0..MAX_RD_STREAK):
- increments on a read grant while the FIFO is non-empty;
- clears on any write grant or when the FIFO is empty;
- saturates at MAX_RD_STREAK.
REQ-027 Idle cycles: mem_en=0, mem_we=0; mem_addr/mem_wdata are don't-care but driven to 0.
REQ-028 Memory port: at most one access per cycle; never a read and a write in the same cycle.

Reset
REQ-029 While rst=1 at an edge:
- FIFO emptied (count=0, pointers 0), rd_streak=0;
- lcd_rd_valid=0, lcd_rd_data=0;
- any read granted in that cycle is discarded;
- buffered writes are lost.
REQ-030 While rst is high, all outputs are 0 (cpu_stall=0, lcd_rd_gnt=0, mem_en=0) and inputs are ignored.

Verification
REQ-031 Writes to addrs 1,2,3 (data 0xA,0xB,0xC), no LCD requests -> three consecutive mem writes in order, cpu_stall never asserted.
REQ-032 5 back-to-back writes with lcd_rd_req held high -> FIFO fills; cpu_stall=1 at count 4; the 5th strobe during stall is dropped; write grant is forced when full.
REQ-033 lcd_rd_req continuous, FIFO holding 1 entry -> exactly MAX_RD_STREAK=4 read grants, then 1 write grant, then reads resume.
REQ-034 Write addr 0x05 data 0x1FF buffered, LCD reads 0x05 before drain -> mem_en=0 that cycle; next cycle lcd_rd_valid=1, lcd_rd_data=0x1FF.
REQ-035 Read of addr 0x10 with mem_rdata=0x0AB -> gnt at cycle N, mem_en=1/mem_we=0; lcd_rd_valid and lcd_rd_data=0x0AB at N+1.
REQ-036 rst pulsed with 3 entries buffered and a read granted -> next cycle count=0, lcd_rd_valid=0, no mem access.
